// File: rtl/axi_txn_limiter.sv
// Outstanding-transaction limiter and quiesce controller between a core AXI port and an external port.
// Requests and responses pass straight through; only AR/AW valid/ready are gated.
module axi_txn_limiter #(
  parameter int unsigned AXI_ID_WIDTH      = 4,
  parameter int unsigned AXI_ADDRESS_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH    = 64,
  parameter int unsigned AXI_USER_WIDTH    = 1,
  parameter int unsigned MAX_RD_TXNS       = 8,
  parameter int unsigned MAX_WR_TXNS       = 8,
  localparam int unsigned AXW      = AXI_ID_WIDTH + AXI_ADDRESS_WIDTH + AXI_USER_WIDTH + 29,
  localparam int unsigned AWW      = AXW + 6,
  localparam int unsigned WW       = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + AXI_USER_WIDTH,
  localparam int unsigned BW       = AXI_ID_WIDTH + AXI_USER_WIDTH + 2,
  localparam int unsigned RW       = AXI_ID_WIDTH + AXI_DATA_WIDTH + AXI_USER_WIDTH + 2,
  localparam int unsigned MAX_TXNS = (MAX_RD_TXNS > MAX_WR_TXNS) ? MAX_RD_TXNS : MAX_WR_TXNS,
  localparam int unsigned CW       = $clog2(MAX_TXNS + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            slv_aw_valid_i,
  output logic            slv_aw_ready_o,
  input  logic [AWW-1:0]  slv_aw_bits_i,
  input  logic            slv_w_valid_i,
  output logic            slv_w_ready_o,
  input  logic [WW-1:0]   slv_w_bits_i,
  input  logic            slv_w_last_i,
  input  logic            slv_ar_valid_i,
  output logic            slv_ar_ready_o,
  input  logic [AXW-1:0]  slv_ar_bits_i,
  output logic            slv_b_valid_o,
  input  logic            slv_b_ready_i,
  output logic [BW-1:0]   slv_b_bits_o,
  output logic            slv_r_valid_o,
  input  logic            slv_r_ready_i,
  output logic [RW-1:0]   slv_r_bits_o,
  output logic            slv_r_last_o,
  output logic            mst_aw_valid_o,
  input  logic            mst_aw_ready_i,
  output logic [AWW-1:0]  mst_aw_bits_o,
  output logic            mst_w_valid_o,
  input  logic            mst_w_ready_i,
  output logic [WW-1:0]   mst_w_bits_o,
  output logic            mst_w_last_o,
  output logic            mst_ar_valid_o,
  input  logic            mst_ar_ready_i,
  output logic [AXW-1:0]  mst_ar_bits_o,
  input  logic            mst_b_valid_i,
  output logic            mst_b_ready_o,
  input  logic [BW-1:0]   mst_b_bits_i,
  input  logic            mst_r_valid_i,
  output logic            mst_r_ready_o,
  input  logic [RW-1:0]   mst_r_bits_i,
  input  logic            mst_r_last_i,
  input  logic            quiesce_req_i,
  output logic            quiesce_ack_o,
  output logic [CW-1:0]   rd_outstanding_o,
  output logic [CW-1:0]   wr_outstanding_o,
  output logic [15:0]     err_count_o,
  output logic            proto_err_o
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_QUIESCED} state_t;

  state_t          r_state, w_state_nxt;
  logic            r_ack;
  logic [CW-1:0]   r_rd_cnt, r_wr_cnt, r_wbur_cnt;
  logic [15:0]     r_err_cnt;
  logic            r_proto_err;
  logic            w_ar_allow, w_aw_allow, w_drained;
  logic            w_ar_hs, w_aw_hs, w_wl_hs, w_b_hs, w_r_hs, w_rl_hs;
  logic            w_rd_under, w_wr_under, w_wbur_under;
  logic [16:0]     w_err_sum;

  // Payload and handshake pass-through; only AR/AW are gated
  assign mst_aw_valid_o = slv_aw_valid_i & w_aw_allow;
  assign slv_aw_ready_o = mst_aw_ready_i & w_aw_allow;
  assign mst_aw_bits_o  = slv_aw_bits_i;
  assign mst_ar_valid_o = slv_ar_valid_i & w_ar_allow;
  assign slv_ar_ready_o = mst_ar_ready_i & w_ar_allow;
  assign mst_ar_bits_o  = slv_ar_bits_i;
  assign mst_w_valid_o  = slv_w_valid_i;
  assign slv_w_ready_o  = mst_w_ready_i;
  assign mst_w_bits_o   = slv_w_bits_i;
  assign mst_w_last_o   = slv_w_last_i;
  assign slv_b_valid_o  = mst_b_valid_i;
  assign mst_b_ready_o  = slv_b_ready_i;
  assign slv_b_bits_o   = mst_b_bits_i;
  assign slv_r_valid_o  = mst_r_valid_i;
  assign mst_r_ready_o  = slv_r_ready_i;
  assign slv_r_bits_o   = mst_r_bits_i;
  assign slv_r_last_o   = mst_r_last_i;

  assign w_ar_hs = mst_ar_valid_o & mst_ar_ready_i;
  assign w_aw_hs = mst_aw_valid_o & mst_aw_ready_i;
  assign w_wl_hs = slv_w_valid_i & mst_w_ready_i & slv_w_last_i;
  assign w_b_hs  = mst_b_valid_i & slv_b_ready_i;
  assign w_r_hs  = mst_r_valid_i & slv_r_ready_i;
  assign w_rl_hs = w_r_hs & mst_r_last_i;

  assign w_drained = (r_rd_cnt == '0) && (r_wr_cnt == '0) && (r_wbur_cnt == '0);

  // Up/down counter step; a lone decrement at zero holds and is reported as underflow
  function automatic logic [CW-1:0] f_cnt_next(input logic [CW-1:0] cnt, input logic inc,
                                               input logic dec);
    logic [CW-1:0] nxt;
    nxt = cnt;
    if (inc && !dec && (cnt != '1)) nxt = cnt + CW'(1);
    else if (dec && !inc && (cnt != '0)) nxt = cnt - CW'(1);
    return nxt;
  endfunction

  assign w_rd_under   = w_rl_hs & ~w_ar_hs & (r_rd_cnt == '0);
  assign w_wr_under   = w_b_hs & ~w_aw_hs & (r_wr_cnt == '0);
  assign w_wbur_under = w_wl_hs & ~w_aw_hs & (r_wbur_cnt == '0);

  assign w_err_sum = {1'b0, r_err_cnt} + 17'(w_b_hs & mst_b_bits_i[1])
                   + 17'(w_r_hs & mst_r_bits_i[1]);

  // State register; ack is registered alongside the state it reflects
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt == ST_QUIESCED);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:      if (quiesce_req_i) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (!quiesce_req_i) w_state_nxt = ST_RUN;
        else if (w_drained) w_state_nxt = ST_QUIESCED;
      end
      ST_QUIESCED: if (!quiesce_req_i) w_state_nxt = ST_RUN;
      default:     w_state_nxt = ST_RUN;
    endcase
  end

  // Request gating; reset forces the RUN/empty view so requests flow during reset
  always_comb begin
    w_ar_allow = 1'b0;
    w_aw_allow = 1'b0;
    if (rst_i) begin
      w_ar_allow = 1'b1;
      w_aw_allow = 1'b1;
    end else if (r_state == ST_RUN) begin
      w_ar_allow = (r_rd_cnt < CW'(MAX_RD_TXNS));
      w_aw_allow = (r_wr_cnt < CW'(MAX_WR_TXNS));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_wbur_cnt  <= '0;
      r_err_cnt   <= '0;
      r_proto_err <= 1'b0;
    end else begin
      r_rd_cnt   <= f_cnt_next(r_rd_cnt, w_ar_hs, w_rl_hs);
      r_wr_cnt   <= f_cnt_next(r_wr_cnt, w_aw_hs, w_b_hs);
      r_wbur_cnt <= f_cnt_next(r_wbur_cnt, w_aw_hs, w_wl_hs);
      r_err_cnt  <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
      if (w_rd_under || w_wr_under || w_wbur_under) r_proto_err <= 1'b1;
    end
  end

  assign quiesce_ack_o    = r_ack;
  assign rd_outstanding_o = r_rd_cnt;
  assign wr_outstanding_o = r_wr_cnt;
  assign err_count_o      = r_err_cnt;
  assign proto_err_o      = r_proto_err;

endmodule

// File: tb/tb_axi_txn_limiter.sv
// Self-checking bench for axi_txn_limiter: directed scenarios plus randomized traffic
// compared against a counter-level reference model.
module tb_axi_txn_limiter;

  localparam int unsigned ID = 4, ADDR = 32, DATA = 32, USER = 1;
  localparam int MAX_RD = 2, MAX_WR = 4;
  localparam int unsigned AXW = ID + ADDR + USER + 29;
  localparam int unsigned AWW = AXW + 6;
  localparam int unsigned WW  = DATA + DATA / 8 + USER;
  localparam int unsigned BW  = ID + USER + 2;
  localparam int unsigned RW  = ID + DATA + USER + 2;
  localparam int unsigned CW  = 3;

  logic clk = 1'b0, rst_i = 1'b0;
  logic slv_aw_valid_i = 0, slv_aw_ready_o; logic [AWW-1:0] slv_aw_bits_i = '0;
  logic slv_w_valid_i = 0, slv_w_ready_o, slv_w_last_i = 0; logic [WW-1:0] slv_w_bits_i = '0;
  logic slv_ar_valid_i = 0, slv_ar_ready_o; logic [AXW-1:0] slv_ar_bits_i = '0;
  logic slv_b_valid_o, slv_b_ready_i = 0; logic [BW-1:0] slv_b_bits_o;
  logic slv_r_valid_o, slv_r_ready_i = 0, slv_r_last_o; logic [RW-1:0] slv_r_bits_o;
  logic mst_aw_valid_o, mst_aw_ready_i = 0; logic [AWW-1:0] mst_aw_bits_o;
  logic mst_w_valid_o, mst_w_ready_i = 0, mst_w_last_o; logic [WW-1:0] mst_w_bits_o;
  logic mst_ar_valid_o, mst_ar_ready_i = 0; logic [AXW-1:0] mst_ar_bits_o;
  logic mst_b_valid_i = 0, mst_b_ready_o; logic [BW-1:0] mst_b_bits_i = '0;
  logic mst_r_valid_i = 0, mst_r_ready_o, mst_r_last_i = 0; logic [RW-1:0] mst_r_bits_i = '0;
  logic quiesce_req_i = 0, quiesce_ack_o, proto_err_o;
  logic [CW-1:0] rd_outstanding_o, wr_outstanding_o;
  logic [15:0] err_count_o;

  int errors = 0, checks = 0;
  // Reference model: state 0=run 1=drain 2=quiesced
  int m_state = 0, m_rd = 0, m_wr = 0, m_wbur = 0, m_err = 0;
  bit m_proto = 0;

  always #5 clk = ~clk;

  axi_txn_limiter #(.AXI_ID_WIDTH(ID), .AXI_ADDRESS_WIDTH(ADDR), .AXI_DATA_WIDTH(DATA),
                    .AXI_USER_WIDTH(USER), .MAX_RD_TXNS(MAX_RD), .MAX_WR_TXNS(MAX_WR)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .slv_aw_valid_i(slv_aw_valid_i), .slv_aw_ready_o(slv_aw_ready_o), .slv_aw_bits_i(slv_aw_bits_i),
    .slv_w_valid_i(slv_w_valid_i), .slv_w_ready_o(slv_w_ready_o), .slv_w_bits_i(slv_w_bits_i),
    .slv_w_last_i(slv_w_last_i),
    .slv_ar_valid_i(slv_ar_valid_i), .slv_ar_ready_o(slv_ar_ready_o), .slv_ar_bits_i(slv_ar_bits_i),
    .slv_b_valid_o(slv_b_valid_o), .slv_b_ready_i(slv_b_ready_i), .slv_b_bits_o(slv_b_bits_o),
    .slv_r_valid_o(slv_r_valid_o), .slv_r_ready_i(slv_r_ready_i), .slv_r_bits_o(slv_r_bits_o),
    .slv_r_last_o(slv_r_last_o),
    .mst_aw_valid_o(mst_aw_valid_o), .mst_aw_ready_i(mst_aw_ready_i), .mst_aw_bits_o(mst_aw_bits_o),
    .mst_w_valid_o(mst_w_valid_o), .mst_w_ready_i(mst_w_ready_i), .mst_w_bits_o(mst_w_bits_o),
    .mst_w_last_o(mst_w_last_o),
    .mst_ar_valid_o(mst_ar_valid_o), .mst_ar_ready_i(mst_ar_ready_i), .mst_ar_bits_o(mst_ar_bits_o),
    .mst_b_valid_i(mst_b_valid_i), .mst_b_ready_o(mst_b_ready_o), .mst_b_bits_i(mst_b_bits_i),
    .mst_r_valid_i(mst_r_valid_i), .mst_r_ready_o(mst_r_ready_o), .mst_r_bits_i(mst_r_bits_i),
    .mst_r_last_i(mst_r_last_i),
    .quiesce_req_i(quiesce_req_i), .quiesce_ack_o(quiesce_ack_o),
    .rd_outstanding_o(rd_outstanding_o), .wr_outstanding_o(wr_outstanding_o),
    .err_count_o(err_count_o), .proto_err_o(proto_err_o)
  );

  task automatic clear();
    slv_aw_valid_i = 0; mst_aw_ready_i = 0; slv_w_valid_i = 0; mst_w_ready_i = 0; slv_w_last_i = 0;
    slv_ar_valid_i = 0; mst_ar_ready_i = 0; mst_b_valid_i = 0; slv_b_ready_i = 0;
    mst_r_valid_i = 0; slv_r_ready_i = 0; mst_r_last_i = 0; mst_b_bits_i = '0; mst_r_bits_i = '0;
  endtask

  // Advance one clock, updating the reference model from the inputs held this cycle
  task automatic tick();
    bit ar_ok, aw_ok;
    int ar_hs, aw_hs, wl_hs, b_hs, r_hs, rl_hs, nxt;
    ar_ok = rst_i || (m_state == 0 && m_rd < MAX_RD);
    aw_ok = rst_i || (m_state == 0 && m_wr < MAX_WR);
    ar_hs = (slv_ar_valid_i && mst_ar_ready_i && ar_ok) ? 1 : 0;
    aw_hs = (slv_aw_valid_i && mst_aw_ready_i && aw_ok) ? 1 : 0;
    wl_hs = (slv_w_valid_i && mst_w_ready_i && slv_w_last_i) ? 1 : 0;
    b_hs  = (mst_b_valid_i && slv_b_ready_i) ? 1 : 0;
    r_hs  = (mst_r_valid_i && slv_r_ready_i) ? 1 : 0;
    rl_hs = (r_hs == 1 && mst_r_last_i) ? 1 : 0;
    if (rst_i) begin
      m_state = 0; m_rd = 0; m_wr = 0; m_wbur = 0; m_err = 0; m_proto = 0;
    end else begin
      nxt = m_state;
      if (m_state == 0 && quiesce_req_i) nxt = 1;
      else if (m_state == 1 && !quiesce_req_i) nxt = 0;
      else if (m_state == 1 && m_rd == 0 && m_wr == 0 && m_wbur == 0) nxt = 2;
      else if (m_state == 2 && !quiesce_req_i) nxt = 0;
      m_state = nxt;
      m_rd = m_rd + ar_hs - rl_hs;
      if (m_rd < 0) begin m_rd = 0; m_proto = 1; end
      m_wr = m_wr + aw_hs - b_hs;
      if (m_wr < 0) begin m_wr = 0; m_proto = 1; end
      m_wbur = m_wbur + aw_hs - wl_hs;
      if (m_wbur < 0) begin m_wbur = 0; m_proto = 1; end
      if (m_wbur > 7) m_wbur = 7;
      m_err = m_err + ((b_hs == 1 && mst_b_bits_i[1]) ? 1 : 0) + ((r_hs == 1 && mst_r_bits_i[1]) ? 1 : 0);
      if (m_err > 65535) m_err = 65535;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_i = 1; quiesce_req_i = 0; clear();
    tick(); tick();
    rst_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    if ({rd_outstanding_o, wr_outstanding_o} !== 6'd0) begin errors++;
      $display("FAIL reset_cnt: got rd=%0d wr=%0d want 0 0", rd_outstanding_o, wr_outstanding_o); end
    checks++;
    if ({quiesce_ack_o, proto_err_o, err_count_o} !== 18'd0) begin errors++;
      $display("FAIL reset_flags: got ack=%b proto=%b err=%0d want 0 0 0", quiesce_ack_o, proto_err_o, err_count_o); end
    checks++;
  endtask

  task automatic test_read_limit();
    logic [CW-1:0] exp_rd [4] = '{3'd1, 3'd2, 3'd2, 3'd1};
    logic exp_rdy [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    slv_ar_valid_i = 1; mst_ar_ready_i = 1; slv_ar_bits_i = AXW'(66'h1_2345_6789_ABCD);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin mst_r_valid_i = 1; slv_r_ready_i = 1; mst_r_last_i = 1; end
      #1;
      if (slv_ar_ready_o !== exp_rdy[i]) begin errors++;
        $display("FAIL ar_limit_ready[%0d]: got %b want %b", i, slv_ar_ready_o, exp_rdy[i]); end
      checks++;
      tick();
      if (rd_outstanding_o !== exp_rd[i]) begin errors++;
        $display("FAIL ar_limit_cnt[%0d]: got %0d want %0d", i, rd_outstanding_o, exp_rd[i]); end
      checks++;
    end
    clear(); slv_ar_valid_i = 1; mst_ar_ready_i = 1; #1;
    if (mst_ar_bits_o !== slv_ar_bits_i || slv_ar_ready_o !== 1'b1) begin errors++;
      $display("FAIL ar_resume: got ready=%b bits=%h want 1 %h", slv_ar_ready_o, mst_ar_bits_o, slv_ar_bits_i); end
    checks++;
    tick(); clear();
  endtask

  task automatic test_same_cycle();
    do_reset();
    slv_aw_valid_i = 1; mst_aw_ready_i = 1; slv_w_valid_i = 1; mst_w_ready_i = 1; slv_w_last_i = 1;
    tick(); tick(); tick();
    mst_b_valid_i = 1; slv_b_ready_i = 1; #1;
    if (slv_aw_ready_o !== 1'b1) begin errors++;
      $display("FAIL aw_b_ready: got %b want 1", slv_aw_ready_o); end
    checks++;
    tick();
    if (wr_outstanding_o !== 3'd3) begin errors++;
      $display("FAIL aw_b_same: got %0d want 3", wr_outstanding_o); end
    checks++;
    mst_b_valid_i = 0; tick();
    #1;
    if (wr_outstanding_o !== 3'd4 || slv_aw_ready_o !== 1'b0 || mst_aw_valid_o !== 1'b0) begin errors++;
      $display("FAIL aw_at_max: got cnt=%0d ready=%b valid=%b want 4 0 0", wr_outstanding_o, slv_aw_ready_o, mst_aw_valid_o); end
    checks++;
    clear();
  endtask

  task automatic test_err_count();
    do_reset();
    slv_ar_valid_i = 1; mst_ar_ready_i = 1; slv_aw_valid_i = 1; mst_aw_ready_i = 1;
    slv_w_valid_i = 1; mst_w_ready_i = 1; slv_w_last_i = 1;
    tick(); clear();
    mst_b_valid_i = 1; slv_b_ready_i = 1; mst_b_bits_i = BW'(2'b10); tick(); clear();
    for (int i = 0; i < 4; i++) begin
      mst_r_valid_i = 1; slv_r_ready_i = 1; mst_r_bits_i = RW'(2'b11); mst_r_last_i = (i == 3);
      tick();
    end
    clear();
    if (err_count_o !== 16'd5 || proto_err_o !== 1'b0) begin errors++;
      $display("FAIL err_count: got %0d proto=%b want 5 0", err_count_o, proto_err_o); end
    checks++;
    if ({rd_outstanding_o, wr_outstanding_o} !== 6'd0) begin errors++;
      $display("FAIL err_cnts_idle: got rd=%0d wr=%0d want 0 0", rd_outstanding_o, wr_outstanding_o); end
    checks++;
  endtask

  task automatic test_err_saturate();
    do_reset();
    slv_aw_valid_i = 1; mst_aw_ready_i = 1; slv_w_valid_i = 1; mst_w_ready_i = 1; slv_w_last_i = 1;
    mst_b_valid_i = 1; slv_b_ready_i = 1; mst_b_bits_i = BW'(2'b10);
    mst_r_valid_i = 1; slv_r_ready_i = 1; mst_r_bits_i = RW'(2'b11); mst_r_last_i = 0;
    for (int i = 0; i < 32767; i++) tick();
    if (err_count_o !== 16'hFFFE) begin errors++;
      $display("FAIL err_preload: got %h want fffe", err_count_o); end
    checks++;
    tick();
    if (err_count_o !== 16'hFFFF) begin errors++;
      $display("FAIL err_sat: got %h want ffff", err_count_o); end
    checks++;
    tick();
    if (err_count_o !== 16'hFFFF || proto_err_o !== 1'b0) begin errors++;
      $display("FAIL err_sat_hold: got %h proto=%b want ffff 0", err_count_o, proto_err_o); end
    checks++;
    clear();
  endtask

  task automatic test_quiesce();
    do_reset();
    slv_ar_valid_i = 1; mst_ar_ready_i = 1; slv_aw_valid_i = 1; mst_aw_ready_i = 1;
    slv_w_valid_i = 1; mst_w_ready_i = 1; slv_w_last_i = 0;
    tick(); clear();
    quiesce_req_i = 1; tick();
    slv_ar_valid_i = 1; mst_ar_ready_i = 1; slv_aw_valid_i = 1; mst_aw_ready_i = 1; mst_w_ready_i = 1;
    #1;
    if ({slv_ar_ready_o, mst_ar_valid_o, slv_aw_ready_o, mst_aw_valid_o} !== 4'b0000 || slv_w_ready_o !== 1'b1) begin errors++;
      $display("FAIL drain_gate: got ar=%b%b aw=%b%b w=%b want 00 00 1", slv_ar_ready_o, mst_ar_valid_o,
               slv_aw_ready_o, mst_aw_valid_o, slv_w_ready_o); end
    checks++;
    mst_r_valid_i = 1; slv_r_ready_i = 1; mst_r_last_i = 1; tick(); mst_r_valid_i = 0;
    slv_w_valid_i = 1; slv_w_last_i = 1; tick(); slv_w_valid_i = 0;
    mst_b_valid_i = 1; slv_b_ready_i = 1; tick(); mst_b_valid_i = 0;
    if (quiesce_ack_o !== 1'b0 || {rd_outstanding_o, wr_outstanding_o} !== 6'd0) begin errors++;
      $display("FAIL drain_wait: got ack=%b rd=%0d wr=%0d want 0 0 0", quiesce_ack_o, rd_outstanding_o, wr_outstanding_o); end
    checks++;
    tick();
    if (quiesce_ack_o !== 1'b1 || slv_ar_ready_o !== 1'b0) begin errors++;
      $display("FAIL quiesced: got ack=%b ar_ready=%b want 1 0", quiesce_ack_o, slv_ar_ready_o); end
    checks++;
    quiesce_req_i = 0; tick();
    if (quiesce_ack_o !== 1'b0 || slv_ar_ready_o !== 1'b1) begin errors++;
      $display("FAIL resume: got ack=%b ar_ready=%b want 0 1", quiesce_ack_o, slv_ar_ready_o); end
    checks++;
    tick();
    if (rd_outstanding_o !== 3'd1 || wr_outstanding_o !== 3'd1) begin errors++;
      $display("FAIL resume_traffic: got rd=%0d wr=%0d want 1 1", rd_outstanding_o, wr_outstanding_o); end
    checks++;
    clear();
  endtask

  task automatic test_quiesce_idle();
    do_reset();
    quiesce_req_i = 1; tick();
    if (quiesce_ack_o !== 1'b0) begin errors++;
      $display("FAIL idle_drain: got ack=%b want 0", quiesce_ack_o); end
    checks++;
    tick();
    if (quiesce_ack_o !== 1'b1) begin errors++;
      $display("FAIL idle_quiesced: got ack=%b want 1", quiesce_ack_o); end
    checks++;
    quiesce_req_i = 0; tick();
  endtask

  task automatic test_proto_err();
    do_reset();
    mst_b_valid_i = 1; slv_b_ready_i = 1; tick(); clear();
    if (proto_err_o !== 1'b1 || wr_outstanding_o !== 3'd0) begin errors++;
      $display("FAIL proto_set: got proto=%b wr=%0d want 1 0", proto_err_o, wr_outstanding_o); end
    checks++;
    for (int i = 0; i < 5; i++) tick();
    if (proto_err_o !== 1'b1) begin errors++;
      $display("FAIL proto_sticky: got %b want 1", proto_err_o); end
    checks++;
    do_reset();
    if (proto_err_o !== 1'b0) begin errors++;
      $display("FAIL proto_clear: got %b want 0", proto_err_o); end
    checks++;
  endtask

  task automatic test_reset_drain();
    do_reset();
    slv_ar_valid_i = 1; mst_ar_ready_i = 1; tick(); tick(); clear();
    quiesce_req_i = 1; tick(); tick();
    rst_i = 1; slv_ar_valid_i = 1; mst_ar_ready_i = 1; #1;
    if (slv_ar_ready_o !== 1'b1 || mst_ar_valid_o !== 1'b1) begin errors++;
      $display("FAIL rst_passthru: got ready=%b valid=%b want 1 1", slv_ar_ready_o, mst_ar_valid_o); end
    checks++;
    tick();
    rst_i = 0; quiesce_req_i = 0; clear();
    if ({rd_outstanding_o, wr_outstanding_o, quiesce_ack_o, proto_err_o} !== 8'd0) begin errors++;
      $display("FAIL rst_drain: got rd=%0d wr=%0d ack=%b proto=%b want 0 0 0 0", rd_outstanding_o,
               wr_outstanding_o, quiesce_ack_o, proto_err_o); end
    checks++;
    mst_r_valid_i = 1; slv_r_ready_i = 1; mst_r_last_i = 1; tick(); clear();
    if (proto_err_o !== 1'b1 || rd_outstanding_o !== 3'd0) begin errors++;
      $display("FAIL stale_r: got proto=%b rd=%0d want 1 0", proto_err_o, rd_outstanding_o); end
    checks++;
  endtask

  task automatic test_random();
    bit exp_ar, exp_aw;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      slv_ar_valid_i = 1'($urandom_range(0, 1)); mst_ar_ready_i = 1'($urandom_range(0, 3) != 0);
      slv_aw_valid_i = 1'($urandom_range(0, 1)); mst_aw_ready_i = 1'($urandom_range(0, 3) != 0);
      slv_w_valid_i = 1'($urandom_range(0, 1)); mst_w_ready_i = 1'($urandom_range(0, 1));
      slv_w_last_i = 1'($urandom_range(0, 4) != 0);
      mst_b_valid_i = 1'($urandom_range(0, 2) == 0); slv_b_ready_i = 1'($urandom_range(0, 1));
      mst_r_valid_i = 1'($urandom_range(0, 2) == 0); slv_r_ready_i = 1'($urandom_range(0, 1));
      mst_r_last_i = 1'($urandom_range(0, 1));
      mst_b_bits_i = BW'($urandom()); mst_r_bits_i = RW'({$urandom(), $urandom()});
      slv_ar_bits_i = AXW'({$urandom(), $urandom(), $urandom()});
      if ($urandom_range(0, 19) == 0) quiesce_req_i = ~quiesce_req_i;
      rst_i = ($urandom_range(0, 199) == 0);
      #1;
      exp_ar = rst_i || (m_state == 0 && m_rd < MAX_RD);
      exp_aw = rst_i || (m_state == 0 && m_wr < MAX_WR);
      if (slv_ar_ready_o !== (mst_ar_ready_i & exp_ar) || mst_ar_valid_o !== (slv_ar_valid_i & exp_ar) ||
          slv_aw_ready_o !== (mst_aw_ready_i & exp_aw) || mst_aw_valid_o !== (slv_aw_valid_i & exp_aw)) begin
        errors++;
        $display("FAIL rnd_gate[%0d]: got ar=%b%b aw=%b%b want allow ar=%b aw=%b", i, slv_ar_ready_o,
                 mst_ar_valid_o, slv_aw_ready_o, mst_aw_valid_o, exp_ar, exp_aw);
      end
      checks++;
      if (slv_r_bits_o !== mst_r_bits_i || slv_b_valid_o !== mst_b_valid_i || mst_ar_bits_o !== slv_ar_bits_i ||
          slv_w_ready_o !== mst_w_ready_i) begin
        errors++;
        $display("FAIL rnd_pass[%0d]: got r=%h bv=%b ar=%h wr=%b", i, slv_r_bits_o, slv_b_valid_o, mst_ar_bits_o, slv_w_ready_o);
      end
      checks++;
      tick();
      if (rd_outstanding_o !== CW'(m_rd) || wr_outstanding_o !== CW'(m_wr) || err_count_o !== 16'(m_err) ||
          proto_err_o !== m_proto || quiesce_ack_o !== (m_state == 2)) begin
        errors++;
        $display("FAIL rnd_state[%0d]: got rd=%0d wr=%0d err=%0d proto=%b ack=%b want %0d %0d %0d %b %b", i,
                 rd_outstanding_o, wr_outstanding_o, err_count_o, proto_err_o, quiesce_ack_o,
                 m_rd, m_wr, m_err, m_proto, m_state == 2);
      end
      checks++;
    end
    rst_i = 0; clear();
  endtask

  initial begin
    test_reset();
    test_read_limit();
    test_same_cycle();
    test_err_count();
    test_err_saturate();
    test_quiesce();
    test_quiesce_idle();
    test_proto_err();
    test_reset_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
